// File: rtl/vga_controller.sv
// VGA timing generator: divides the system clock by two into a pixel enable,
// runs the horizontal/vertical counters on that enable, decodes sync and
// blanking from the live counter values, and counts completed frames.
module vga_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width copies of the timing boundaries, so every compare is 10 bits.
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_END    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_en_q, pix_en_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (hcnt_q == H_LAST);
  assign v_wrap = (vcnt_q == V_LAST);

  // Next-state: toggle the pixel enable, advance counters on enabled edges,
  // and flag the frame wrap so the pulse lines up with the (0,0) counters.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned; a missing default here would infer a latch.
    pix_en_d      = ~pix_en_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (pix_en_q) begin
      if (h_wrap) begin
        hcnt_d = '0;
        if (v_wrap) begin
          vcnt_d        = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end else begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // State registers; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      pix_en_q      <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      pix_en_q      <= pix_en_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Sync and blanking are decoded straight from the counters so they never
  // lag x/y.
  assign hsync   = ~((hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END));
  assign vsync   = ~((vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END));
  assign blank_n = (hcnt_q < H_VIS_END) && (vcnt_q < V_VIS_END);

  assign vga_clk     = pix_en_q;
  assign sync_n      = 1'b0;
  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
